move_scheduler: RTL and testbench
=================================

Name: move_scheduler

Overview:
- Sequences the block-position datapath. Takes raw up/down/left/right buttons, synchronizes and debounces them, and arbitrates to one winning direction.
- Issues one move command per press over a valid/ready handshake to the position register logic.
- Auto-repeats at frame rate while a button is held.
- Sits between the board buttons and the position-update logic, clocked on the same slow clk.

Parameters:
- DEBOUNCE_CYCLES, 8, number of clk cycles a synchronized level must stay constant before the stable state changes.
- REPEAT_DELAY, 20, frame_ticks counted after the first accepted move before auto-repeat starts.
- REPEAT_PERIOD, 4, frame_ticks between repeated moves.
- STEP, 2, pixel step size reported on move_step (4 bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- up, down, left, right  in  1 each  raw asynchronous buttons
- move_ready  in  1  position datapath accepts a command
- move_valid  out  1  command pending
- move_dir  out  2  0=right, 1=left, 2=up, 3=down
- move_step  out  4  pixels to move
- btn_stable  out  4  debounced mask {down,up,left,right}

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high. All state updates on posedge clk.
- Reset values:
  - move_valid=0, move_dir=0, move_step=STEP, btn_stable=0.
  - Debounce counters=0, repeat counter=0, FSM=IDLE.
  - Reset asserted mid-handshake drops move_valid the next cycle; no command is considered accepted.
- Input synchronization: each button passes through a 2-flop synchronizer.
- Debounce: per-button counter resets to 0 whenever the synchronized level equals btn_stable; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, btn_stable toggles and the counter clears. A press is therefore visible 2+DEBOUNCE_CYCLES cycles after the raw edge.
- Arbitration (combinational on btn_stable):
  - right and left both set: horizontal axis cancelled. up and down both set: vertical axis cancelled.
  - Among the remaining buttons, priority is right > left > up > down. winner_valid=0 if none remain.
- FSM states IDLE, ISSUE, HOLD, REPEAT:
  - IDLE: if winner_valid, latch move_dir=winner, assert move_valid, go to ISSUE.
  - ISSUE:
    - move_valid and move_dir stay stable until move_valid&&move_ready; a command is never retracted, even if the button is released.
    - On acceptance: drop move_valid the same edge, clear the repeat counter, and go to HOLD if this was the first move of the press, else REPEAT.
  - HOLD: count frame_ticks. At REPEAT_DELAY, re-issue the same direction (go to ISSUE).
  - REPEAT: count frame_ticks. At REPEAT_PERIOD, re-issue.
  - HOLD/REPEAT exits:
    - winner_valid=0: go to IDLE.
    - Winner differs from the latched move_dir: re-issue immediately with the new direction, treated as a first move (next wait is HOLD).
- Boundary rules:
  - frame_tick in the same cycle as acceptance is not counted.
  - Repeat counter saturates and never wraps.
  - Back-to-back acceptance is allowed: at most one command per 2 cycles.

Optional Feature:
MOVE_SCHED_ACCEL_EN
- Defined: after 4 consecutive accepted repeats in one hold, move_step = 2*STEP (saturating at 15). It returns to STEP on release, direction change, or reset.
- Undefined: move_step is constant STEP; the repeat-count register is not built.

Decomposition:
- Shared package move_pkg:
  - direction encoding constants DIR_RIGHT/LEFT/UP/DOWN
  - FSM state enum
  - button mask bit indices
- Sub-module button_debouncer (synchronizer + counter + stable flop), instantiated 4x, parameterized by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, STEP=2, move_ready=1 unless stated):
1. rst held 3 cycles -> move_valid=0, btn_stable=0, move_step=2. Raw right pulse of 2 cycles -> btn_stable stays 0, no command.
2. right held -> btn_stable[0]=1 after 6 cycles, move_valid=1 with dir=0 next cycle. After 3 frame_ticks another move, then one every 2 frame_ticks until release.
3. move_ready=0 for 10 cycles while valid, button released meanwhile -> valid and dir=0 held stable; one accept on ready, then IDLE with no further moves.
4. right+left+up held together -> dir=2 (horizontal cancelled). All four held -> no command issued.
5. Holding up, add right -> immediate move with dir=0, followed by a 3-tick HOLD before repeats.
6. MOVE_SCHED_ACCEL_EN defined, right held through 5 repeats -> move_step=2 for the first move and repeats 1-4, then 4. Release and press again -> 2.

Source files
------------

// File: rtl/move_pkg.sv
// Shared definitions for the move scheduler: direction codes, button mask bit
// positions, FSM state encoding and the accelerated step helper.
package move_pkg;

  // move_dir encoding; also equals the btn_stable bit index of that button
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // btn_stable mask bit indices: {down, up, left, right}
  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;

  // Accepted repeats in one hold before the step doubles
  localparam int unsigned ACCEL_REPEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  // Double step, saturated to the 4-bit move_step range
  function automatic logic [3:0] accel_step(input int unsigned step);
    int unsigned s;
    s = 2 * step;
    if (s > 15) s = 15;
    return s[3:0];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Single-button conditioner: 2-flop synchronizer followed by a debounce
// counter and the stable-level flop.
//   clk       system clock
//   rst       synchronous active-high reset
//   btn_i     raw asynchronous button level
//   stable_o  debounced level; a change appears 2+DEBOUNCE_CYCLES cycles
//             after the raw edge
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= ~stable_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: debounces the four direction buttons, arbitrates to one
// direction and issues move commands over a valid/ready handshake, with
// frame-rate auto-repeat while the button stays held.
//   clk, rst            clock, synchronous active-high reset
//   frame_tick          one-cycle pulse per video frame
//   up/down/left/right  raw asynchronous buttons
//   move_ready          position datapath accepts the pending command
//   move_valid          command pending
//   move_dir            0=right, 1=left, 2=up, 3=down
//   move_step           pixels to move
//   btn_stable          debounced mask {down, up, left, right}
// Build option: MOVE_SCHED_ACCEL_EN doubles move_step after four consecutive
// accepted repeats within one hold; undefined keeps move_step at STEP.
module move_scheduler
  import move_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 4,
  parameter int unsigned STEP            = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] move_step,
  output logic [3:0] btn_stable
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW     = $clog2(RPT_MAX + 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);
  localparam logic [3:0]     BASE_STEP   = 4'(STEP);

  logic [3:0]     stab;
  logic           winner_valid;
  logic [1:0]     winner;
  state_e         state_q;
  logic           valid_q;
  logic [1:0]     dir_q;
  logic           first_q;
  logic [RCW-1:0] rpt_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .btn_i(right), .stable_o(stab[BTN_RIGHT]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .btn_i(left), .stable_o(stab[BTN_LEFT]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_i(up), .stable_o(stab[BTN_UP]));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_i(down), .stable_o(stab[BTN_DOWN]));

  // Opposing buttons on one axis cancel that axis; then right > left > up > down
  always_comb begin
    logic h_ok;
    logic v_ok;
    h_ok         = ~(stab[BTN_RIGHT] & stab[BTN_LEFT]);
    v_ok         = ~(stab[BTN_UP] & stab[BTN_DOWN]);
    winner_valid = 1'b1;
    winner       = DIR_RIGHT;
    if (h_ok && stab[BTN_RIGHT])     winner = DIR_RIGHT;
    else if (h_ok && stab[BTN_LEFT]) winner = DIR_LEFT;
    else if (v_ok && stab[BTN_UP])   winner = DIR_UP;
    else if (v_ok && stab[BTN_DOWN]) winner = DIR_DOWN;
    else                             winner_valid = 1'b0;
  end

  // first_q marks a command that starts a press (or a direction change), so
  // its acceptance leads to the longer HOLD wait rather than REPEAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      dir_q   <= DIR_RIGHT;
      first_q <= 1'b1;
      rpt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (winner_valid) begin
            dir_q   <= winner;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Never retracted; frame_tick here is intentionally ignored
          if (move_ready) begin
            valid_q <= 1'b0;
            rpt_q   <= '0;
            state_q <= first_q ? ST_HOLD : ST_REPEAT;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!winner_valid) begin
            state_q <= ST_IDLE;
          end else if (winner != dir_q) begin
            dir_q   <= winner;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            state_q <= ST_ISSUE;
          end else if (frame_tick) begin
            if (rpt_q == ((state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
              valid_q <= 1'b1;
              first_q <= 1'b0;
              state_q <= ST_ISSUE;
            end else if (rpt_q != '1) begin
              rpt_q <= rpt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MOVE_SCHED_ACCEL_EN
  logic [2:0] acc_q;
  logic [3:0] step_q;

  // Counts accepted repeats of the current hold; release or a new direction
  // (both seen while waiting in HOLD/REPEAT) restore the base step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      step_q <= BASE_STEP;
    end else if (state_q == ST_ISSUE && move_ready && !first_q) begin
      if (acc_q != 3'(ACCEL_REPEATS)) acc_q <= acc_q + 1'b1;
      if (acc_q == 3'(ACCEL_REPEATS - 1)) step_q <= accel_step(STEP);
    end else if ((state_q inside {ST_HOLD, ST_REPEAT}) &&
                 (!winner_valid || winner != dir_q)) begin
      acc_q  <= '0;
      step_q <= BASE_STEP;
    end
  end

  assign move_step = step_q;
`else
  assign move_step = BASE_STEP;
`endif

  assign move_valid = valid_q;
  assign move_dir   = dir_q;
  assign btn_stable = stab;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with DEBOUNCE_CYCLES=4, REPEAT_DELAY=3,
// REPEAT_PERIOD=2, STEP=2.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       move_ready = 1'b1;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] move_step;
  logic [3:0] btn_stable;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  logic [1:0] last_dir = 2'd0;
  logic [3:0] last_step = 4'd0;

`ifdef MOVE_SCHED_ACCEL_EN
  localparam int FAST_STEP = 4;
`else
  localparam int FAST_STEP = 2;
`endif

  typedef struct {
    logic [3:0] btns;      // {down, up, left, right}
    logic       exp_valid;
    logic [1:0] exp_dir;
  } vec_t;

  vec_t vecs[13];

  move_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(3),
    .REPEAT_PERIOD(2),
    .STEP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir(move_dir),
    .move_step(move_step),
    .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;

  // Handshake observer: records every accepted command
  always @(posedge clk) begin
    if (!rst && move_valid === 1'b1 && move_ready === 1'b1) begin
      accepts   <= accepts + 1;
      last_dir  <= move_dir;
      last_step <= move_step;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {down, up, left, right} = 4'b0000;
    frame_tick = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(2);
  endtask

  task automatic wait_accept(input int target, input string name);
    int n;
    n = 0;
    while (accepts < target && n < 40) begin
      step(1);
      n++;
    end
    check(name, accepts, target);
  endtask

  initial begin
    int a;
    int exp_f[7];
    logic hold_ok;

    vecs[0]  = '{4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b0010, 1'b1, 2'd1};
    vecs[2]  = '{4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{4'b0011, 1'b0, 2'd0};
    vecs[5]  = '{4'b1100, 1'b0, 2'd0};
    vecs[6]  = '{4'b0111, 1'b1, 2'd2};
    vecs[7]  = '{4'b1111, 1'b0, 2'd0};
    vecs[8]  = '{4'b1011, 1'b1, 2'd3};
    vecs[9]  = '{4'b1101, 1'b1, 2'd0};
    vecs[10] = '{4'b0110, 1'b1, 2'd1};
    vecs[11] = '{4'b1010, 1'b1, 2'd1};
    vecs[12] = '{4'b0000, 1'b0, 2'd0};
    exp_f = '{1, 1, 2, 2, 3, 3, 4};

    // Reset state, then a glitch shorter than the debounce window
    rst = 1'b1;
    step(3);
    check("rst_valid", move_valid, 0);
    check("rst_stable", btn_stable, 0);
    check("rst_step", move_step, 2);
    check("rst_dir", move_dir, 0);
    rst = 1'b0;
    right = 1'b1;
    step(2);
    right = 1'b0;
    step(10);
    check("glitch_stable", btn_stable, 0);
    check("glitch_accepts", accepts, 0);
    check("glitch_valid", move_valid, 0);

    // Held right: debounce latency, first move, HOLD then REPEAT cadence
    do_reset();
    a = accepts;
    right = 1'b1;
    step(6);
    check("deb_stable", btn_stable, 4'b0001);
    check("deb_valid_early", move_valid, 0);
    step(1);
    check("first_valid", move_valid, 1);
    check("first_dir", move_dir, 0);
    step(1);
    check("first_accept", accepts - a, 1);
    check("first_drop", move_valid, 0);
    for (int i = 0; i < 7; i++) begin
      frame();
      check($sformatf("repeat_frame%0d", i + 1), accepts - a, exp_f[i]);
    end
    check("repeat_dir", last_dir, 0);
    right = 1'b0;
    step(10);
    frame(); frame(); frame();
    check("release_accepts", accepts - a, 4);
    check("release_valid", move_valid, 0);

    // Back-pressure with release during the wait: command held, then one accept
    a = accepts;
    move_ready = 1'b0;
    right = 1'b1;
    step(7);
    check("bp_valid", move_valid, 1);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) right = 1'b0;
      step(1);
      if (!(move_valid === 1'b1 && move_dir === 2'd0)) hold_ok = 1'b0;
    end
    check("bp_stable_hold", hold_ok, 1);
    check("bp_released", btn_stable, 0);
    move_ready = 1'b1;
    step(1);
    check("bp_accept", accepts - a, 1);
    step(5);
    frame(); frame(); frame(); frame();
    check("bp_no_more", accepts - a, 1);
    check("bp_idle_valid", move_valid, 0);

    // Direction change while holding: immediate move, then a full HOLD wait
    a = accepts;
    up = 1'b1;
    wait_accept(a + 1, "chg_up_accept");
    check("chg_up_dir", last_dir, 2);
    right = 1'b1;
    wait_accept(a + 2, "chg_right_accept");
    check("chg_right_dir", last_dir, 0);
    frame(); frame();
    check("chg_hold_wait", accepts - a, 2);
    frame();
    check("chg_hold_repeat", accepts - a, 3);
    check("chg_repeat_dir", last_dir, 0);
    up = 1'b0;
    right = 1'b0;
    step(10);

    // Reset while a command is pending
    do_reset();
    a = accepts;
    move_ready = 1'b0;
    right = 1'b1;
    step(7);
    check("midrst_valid_before", move_valid, 1);
    rst = 1'b1;
    step(1);
    check("midrst_valid_after", move_valid, 0);
    rst = 1'b0;
    right = 1'b0;
    move_ready = 1'b1;
    step(10);
    check("midrst_no_accept", accepts - a, 0);

    // Arbitration table
    for (int i = 0; i < 13; i++) begin
      do_reset();
      move_ready = 1'b0;
      {down, up, left, right} = vecs[i].btns;
      step(9);
      check($sformatf("arb%0d_stable", i), btn_stable, vecs[i].btns);
      check($sformatf("arb%0d_valid", i), move_valid, vecs[i].exp_valid);
      check($sformatf("arb%0d_dir", i), move_dir, vecs[i].exp_dir);
    end
    move_ready = 1'b1;

    // Step size across a long hold, then after re-press
    do_reset();
    a = accepts;
    right = 1'b1;
    wait_accept(a + 1, "acc_first_accept");
    check("acc_first_step", last_step, 2);
    frame(); frame(); frame();
    check("acc_rep1_count", accepts - a, 2);
    check("acc_rep1_step", last_step, 2);
    for (int r = 2; r <= 5; r++) begin
      frame(); frame();
      check($sformatf("acc_rep%0d_count", r), accepts - a, 1 + r);
      check($sformatf("acc_rep%0d_step", r), last_step, (r == 5) ? FAST_STEP : 2);
    end
    check("acc_step_held", move_step, FAST_STEP);
    right = 1'b0;
    step(10);
    check("acc_step_release", move_step, 2);
    a = accepts;
    right = 1'b1;
    wait_accept(a + 1, "acc_repress_accept");
    check("acc_repress_step", last_step, 2);
    right = 1'b0;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
